game_director: RTL and testbench

- Parametrised game-flow controller for the Pac-Man display pipeline; next generation of the game-mode FSM.
- Owns game mode, score, lives, level, frightened (blue-ghost) timing and pacman-vs-N-enemy collision resolution.
- Sits between the movement/candy blocks and the sprite/text renderers, all on vga_pix_clk.
- Replaces wall-clock strobe timers with frame-counted timers.

---
 rtl/game_director_pkg.sv | 36 +++
 rtl/game_director_enemy_hit_detect.sv | 32 +++
 rtl/game_director.sv | 249 ++++++++++++++++++++++++
 tb/tb_game_director.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_director_pkg.sv
// Shared types and default tuning values for the game-flow controller.
package game_director_pkg;

    // Top-level game modes seen by the renderers and movement blocks
    typedef enum logic [2:0] {
        LOADING     = 3'd0,
        READY       = 3'd1,
        PLAY        = 3'd2,
        FRIGHT      = 3'd3,
        DYING       = 3'd4,
        LEVEL_CLEAR = 3'd5,
        GAME_OVER   = 3'd6
    } game_mode_t;

    // Default geometry and scoring
    localparam int DEF_N_ENEMIES      = 4;
    localparam int DEF_POS_W          = 9;
    localparam int DEF_HIT_DIST       = 3;
    localparam int DEF_CANDY_COUNT    = 244;
    localparam int DEF_LIVES          = 3;
    localparam int DEF_SCORE_W        = 16;
    localparam int DEF_POWER_POINTS   = 5;
    localparam int DEF_GHOST_POINTS   = 20;
    localparam int DEF_LEVEL_W        = 4;

    // Default frame-counted durations
    localparam int DEF_LOADING_FRAMES = 60;
    localparam int DEF_FRIGHT_FRAMES  = 360;
    localparam int DEF_DEATH_FRAMES   = 90;
    localparam int DEF_CLEAR_FRAMES   = 120;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/game_director_enemy_hit_detect.sv
// Combinational pacman-vs-enemy proximity test, one bit per enemy channel.
module game_director_enemy_hit_detect #(
    parameter int N_ENEMIES = 4,
    parameter int POS_W     = 9,
    parameter int HIT_DIST  = 3
) (
    input  logic [POS_W-1:0]           x_pac,
    input  logic [POS_W-1:0]           y_pac,
    input  logic [N_ENEMIES*POS_W-1:0] x_enemy,
    input  logic [N_ENEMIES*POS_W-1:0] y_enemy,
    output logic [N_ENEMIES-1:0]       hit
);

    localparam logic [POS_W-1:0] DIST = POS_W'(HIT_DIST);

    // Distance is taken by subtracting the smaller from the larger, so
    // coordinates near 0 and near the top of the range never alias.
    function automatic logic [POS_W-1:0] abs_diff(input logic [POS_W-1:0] a,
                                                  input logic [POS_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Per-channel box test on both axes
    always_comb begin
        hit = '0;
        for (int i = 0; i < N_ENEMIES; i++) begin
            hit[i] = (abs_diff(x_pac, x_enemy[i*POS_W +: POS_W]) <= DIST) &&
                     (abs_diff(y_pac, y_enemy[i*POS_W +: POS_W]) <= DIST);
        end
    end

endmodule

// File: rtl/game_director.sv
// Game-flow controller: mode FSM, frame-counted timer, score, lives, level,
// frightened handling and enemy collision resolution.
module game_director
    import game_director_pkg::*;
#(
    parameter int N_ENEMIES      = DEF_N_ENEMIES,
    parameter int POS_W          = DEF_POS_W,
    parameter int HIT_DIST       = DEF_HIT_DIST,
    parameter int CANDY_COUNT    = DEF_CANDY_COUNT,
    parameter int LIVES          = DEF_LIVES,
    parameter int SCORE_W        = DEF_SCORE_W,
    parameter int POWER_POINTS   = DEF_POWER_POINTS,
    parameter int GHOST_POINTS   = DEF_GHOST_POINTS,
    parameter int LOADING_FRAMES = DEF_LOADING_FRAMES,
    parameter int FRIGHT_FRAMES  = DEF_FRIGHT_FRAMES,
    parameter int DEATH_FRAMES   = DEF_DEATH_FRAMES,
    parameter int CLEAR_FRAMES   = DEF_CLEAR_FRAMES,
    parameter int LEVEL_W        = DEF_LEVEL_W
) (
    input  logic                        vga_pix_clk,
    input  logic                        rst_n,
    input  logic                        frame_stb,
    input  logic                        any_btn,
    input  logic [POS_W-1:0]            x_pac,
    input  logic [POS_W-1:0]            y_pac,
    input  logic [N_ENEMIES*POS_W-1:0]  x_enemy,
    input  logic [N_ENEMIES*POS_W-1:0]  y_enemy,
    input  logic                        ate_candy_stb,
    input  logic                        ate_power_cookie_stb,
    output game_mode_t                  mode,
    output logic                        play_frame_stb,
    output logic                        frightened,
    output logic [N_ENEMIES-1:0]        enemy_respawn,
    output logic                        positions_reset,
    output logic                        map_reload,
    output logic [SCORE_W-1:0]          score,
    output logic [$clog2(LIVES+1)-1:0]  lives,
    output logic [LEVEL_W-1:0]          level
);

    localparam int LIVES_W   = $clog2(LIVES + 1);
    localparam int CAND_W    = $clog2(CANDY_COUNT + 1);
    localparam int TIMER_MAX = max_int(max_int(LOADING_FRAMES, FRIGHT_FRAMES),
                                       max_int(DEATH_FRAMES, CLEAR_FRAMES));
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
    // Headroom so a full cycle's worth of points can be summed before clamping
    localparam int SUM_W     = SCORE_W + 16;

    localparam logic [TIMER_W-1:0] T_LOADING = TIMER_W'(LOADING_FRAMES);
    localparam logic [TIMER_W-1:0] T_FRIGHT  = TIMER_W'(FRIGHT_FRAMES);
    localparam logic [TIMER_W-1:0] T_DEATH   = TIMER_W'(DEATH_FRAMES);
    localparam logic [TIMER_W-1:0] T_CLEAR   = TIMER_W'(CLEAR_FRAMES);
    localparam logic [CAND_W-1:0]  C_FULL    = CAND_W'(CANDY_COUNT);

    game_mode_t             nxt_mode;
    logic [TIMER_W-1:0]     timer, nxt_timer;
    logic [CAND_W-1:0]      candies, nxt_candies;
    logic                   arm, nxt_arm;
    logic [N_ENEMIES-1:0]   eaten, nxt_eaten;
    logic [SCORE_W-1:0]     nxt_score;
    logic [LIVES_W-1:0]     nxt_lives;
    logic [LEVEL_W-1:0]     nxt_level;
    logic [N_ENEMIES-1:0]   nxt_respawn;
    logic                   nxt_pos_reset, nxt_map_reload;

    logic [N_ENEMIES-1:0]   hit, newly_eaten;
    logic                   in_play, cd_stb, pc_stb, expire, any_hit, start, clear_now;
    logic [CAND_W+1:0]      candies_raw;
    logic [CAND_W-1:0]      candies_sum;
    logic [SUM_W-1:0]       ghost_add, score_sum;

    // Clamp a wide score sum to the largest representable score
    function automatic logic [SCORE_W-1:0] sat_score(input logic [SUM_W-1:0] s);
        if (|s[SUM_W-1:SCORE_W]) return '1;
        return s[SCORE_W-1:0];
    endfunction

    // Clamp the candy count at the level-clearing total
    function automatic logic [CAND_W-1:0] sat_candies(input logic [CAND_W+1:0] c);
        if (c >= (CAND_W+2)'(CANDY_COUNT)) return C_FULL;
        return c[CAND_W-1:0];
    endfunction

    // Points for every enemy eaten this cycle, all of them scored
    function automatic logic [SUM_W-1:0] ghost_points(input logic [N_ENEMIES-1:0] v);
        logic [SUM_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < N_ENEMIES; i++) begin
            if (v[i]) acc = acc + SUM_W'(GHOST_POINTS);
        end
        return acc;
    endfunction

    game_director_enemy_hit_detect #(
        .N_ENEMIES (N_ENEMIES),
        .POS_W     (POS_W),
        .HIT_DIST  (HIT_DIST)
    ) u_hit (
        .x_pac   (x_pac),
        .y_pac   (y_pac),
        .x_enemy (x_enemy),
        .y_enemy (y_enemy),
        .hit     (hit)
    );

    assign in_play     = (mode == PLAY) || (mode == FRIGHT);
    assign cd_stb      = in_play && ate_candy_stb;
    assign pc_stb      = in_play && ate_power_cookie_stb;
    assign expire      = frame_stb && (timer == TIMER_W'(1));
    assign any_hit     = |hit;
    assign start       = any_btn && arm;
    assign newly_eaten = hit & ~eaten;
    assign candies_raw = {2'b00, candies} + (CAND_W+2)'(cd_stb) + (CAND_W+2)'(pc_stb);
    assign candies_sum = sat_candies(candies_raw);
    // The increment made this cycle already counts towards clearing the level
    assign clear_now   = in_play && (candies_sum == C_FULL);
    assign ghost_add   = ((mode == FRIGHT) && !clear_now) ? ghost_points(newly_eaten) : '0;
    assign score_sum   = {{(SUM_W-SCORE_W){1'b0}}, score} + SUM_W'(cd_stb)
                       + (pc_stb ? SUM_W'(POWER_POINTS) : '0) + ghost_add;
    assign frightened  = (mode == FRIGHT);

    // Mode register
    always_ff @(posedge vga_pix_clk or negedge rst_n) begin
        if (!rst_n) mode <= LOADING;
        else        mode <= nxt_mode;
    end

    // Next mode; death outranks level clear, which outranks power cookies
    always_comb begin
        nxt_mode = mode;
        case (mode)
            LOADING:     if (expire) nxt_mode = READY;
            READY:       if (start) nxt_mode = PLAY;
            PLAY: begin
                if (any_hit)        nxt_mode = DYING;
                else if (clear_now) nxt_mode = LEVEL_CLEAR;
                else if (pc_stb)    nxt_mode = FRIGHT;
            end
            FRIGHT: begin
                if (clear_now)            nxt_mode = LEVEL_CLEAR;
                else if (!pc_stb && expire) nxt_mode = PLAY;
            end
            DYING:       if (expire) nxt_mode = (lives == LIVES_W'(1)) ? GAME_OVER : READY;
            LEVEL_CLEAR: if (expire) nxt_mode = READY;
            GAME_OVER:   if (start) nxt_mode = LOADING;
            default:     nxt_mode = LOADING;
        endcase
    end

    // Timer, counters, eaten mask, arm and one-cycle pulses for the next cycle
    always_comb begin
        nxt_timer      = timer;
        nxt_candies    = candies;
        nxt_score      = score;
        nxt_lives      = lives;
        nxt_level      = level;
        nxt_eaten      = eaten;
        nxt_arm        = arm;
        nxt_respawn    = '0;
        nxt_pos_reset  = 1'b0;
        nxt_map_reload = 1'b0;

        if (frame_stb && (timer != '0)) nxt_timer = timer - TIMER_W'(1);

        if (in_play) begin
            nxt_candies = candies_sum;
            nxt_score   = sat_score(score_sum);
        end

        case (mode)
            PLAY: begin
                if (any_hit)        nxt_timer = T_DEATH;
                else if (clear_now) nxt_timer = T_CLEAR;
                else if (pc_stb)    nxt_timer = T_FRIGHT;
            end
            FRIGHT: begin
                if (clear_now) begin
                    nxt_timer = T_CLEAR;
                    nxt_eaten = '0;
                end else begin
                    nxt_respawn = newly_eaten;
                    // Set on a new overlap, cleared once the overlap ends
                    nxt_eaten   = hit;
                    if (pc_stb)      nxt_timer = T_FRIGHT;
                    else if (expire) nxt_eaten = '0;
                end
            end
            DYING: begin
                if (expire) begin
                    nxt_lives = lives - LIVES_W'(1);
                    if (lives != LIVES_W'(1)) nxt_pos_reset = 1'b1;
                end
            end
            LEVEL_CLEAR: begin
                if (expire) begin
                    nxt_level      = level + LEVEL_W'(1);
                    nxt_candies    = '0;
                    nxt_map_reload = 1'b1;
                    nxt_pos_reset  = 1'b1;
                end
            end
            GAME_OVER: begin
                if (start) begin
                    nxt_timer      = T_LOADING;
                    nxt_score      = '0;
                    nxt_lives      = LIVES_W'(LIVES);
                    nxt_level      = '0;
                    nxt_candies    = '0;
                    nxt_map_reload = 1'b1;
                end
            end
            default: ;
        endcase

        // Any mode change disarms; a released button arms READY/GAME_OVER
        if (nxt_mode != mode) nxt_arm = 1'b0;
        else if (((mode == READY) || (mode == GAME_OVER)) && !any_btn) nxt_arm = 1'b1;
    end

    // Datapath and pulse registers
    always_ff @(posedge vga_pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            timer           <= T_LOADING;
            candies         <= '0;
            score           <= '0;
            lives           <= LIVES_W'(LIVES);
            level           <= '0;
            eaten           <= '0;
            arm             <= 1'b0;
            enemy_respawn   <= '0;
            positions_reset <= 1'b0;
            map_reload      <= 1'b0;
            play_frame_stb  <= 1'b0;
        end else begin
            timer           <= nxt_timer;
            candies         <= nxt_candies;
            score           <= nxt_score;
            lives           <= nxt_lives;
            level           <= nxt_level;
            eaten           <= nxt_eaten;
            arm             <= nxt_arm;
            enemy_respawn   <= nxt_respawn;
            positions_reset <= nxt_pos_reset;
            map_reload      <= nxt_map_reload;
            play_frame_stb  <= frame_stb && in_play;
        end
    end

endmodule

// File: tb/tb_game_director.sv
// Randomised and directed bench for game_director with a behavioural model.
module tb_game_director;
    import game_director_pkg::*;

    localparam int NE = 4;
    localparam int PW = 9;
    localparam int HD = 3;
    localparam int CC = 12;
    localparam int LV = 2;
    localparam int SW = 8;
    localparam int PP = 5;
    localparam int GP = 20;
    localparam int LF = 60;
    localparam int FF = 360;
    localparam int DF = 90;
    localparam int CF = 120;
    localparam int LW = 4;

    logic              vga_pix_clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              frame_stb = 1'b0;
    logic              any_btn = 1'b0;
    logic [PW-1:0]     x_pac = 9'd100;
    logic [PW-1:0]     y_pac = 9'd100;
    logic [NE*PW-1:0]  x_enemy = {NE{9'd300}};
    logic [NE*PW-1:0]  y_enemy = {NE{9'd300}};
    logic              ate_candy_stb = 1'b0;
    logic              ate_power_cookie_stb = 1'b0;
    game_mode_t        mode;
    logic              play_frame_stb, frightened, positions_reset, map_reload;
    logic [NE-1:0]     enemy_respawn;
    logic [SW-1:0]     score;
    logic [1:0]        lives;
    logic [LW-1:0]     level;

    int total = 0;
    int bad = 0;
    bit check_en = 1'b0;

    game_mode_t m_mode;
    int m_timer, m_score, m_lives, m_level, m_candies;
    bit m_arm, m_pfs, m_pos_reset, m_map_reload;
    bit [NE-1:0] m_eaten, m_respawn;

    game_director #(
        .N_ENEMIES(NE), .POS_W(PW), .HIT_DIST(HD), .CANDY_COUNT(CC), .LIVES(LV),
        .SCORE_W(SW), .POWER_POINTS(PP), .GHOST_POINTS(GP), .LOADING_FRAMES(LF),
        .FRIGHT_FRAMES(FF), .DEATH_FRAMES(DF), .CLEAR_FRAMES(CF), .LEVEL_W(LW)
    ) dut (
        .vga_pix_clk(vga_pix_clk), .rst_n(rst_n), .frame_stb(frame_stb), .any_btn(any_btn),
        .x_pac(x_pac), .y_pac(y_pac), .x_enemy(x_enemy), .y_enemy(y_enemy),
        .ate_candy_stb(ate_candy_stb), .ate_power_cookie_stb(ate_power_cookie_stb),
        .mode(mode), .play_frame_stb(play_frame_stb), .frightened(frightened),
        .enemy_respawn(enemy_respawn), .positions_reset(positions_reset),
        .map_reload(map_reload), .score(score), .lives(lives), .level(level)
    );

    always #5 vga_pix_clk = ~vga_pix_clk;

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
        end
    endtask

    // True pixel distance, no modular wrap
    function automatic bit near(input int a, input int b);
        int d;
        d = a - b;
        if (d < 0) d = -d;
        return d <= HD;
    endfunction

    task automatic model_reset();
        m_mode = LOADING; m_timer = LF; m_score = 0; m_lives = LV; m_level = 0;
        m_candies = 0; m_arm = 0; m_eaten = '0; m_respawn = '0;
        m_pfs = 0; m_pos_reset = 0; m_map_reload = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_advance();
        bit [NE-1:0] h, fresh;
        bit in_play, expired, start, cd, pc;
        int nc, ns;
        game_mode_t nm;
        for (int i = 0; i < NE; i++)
            h[i] = near(int'(x_pac), int'(x_enemy[i*PW +: PW])) &&
                   near(int'(y_pac), int'(y_enemy[i*PW +: PW]));
        in_play = (m_mode == PLAY) || (m_mode == FRIGHT);
        cd = in_play && ate_candy_stb;
        pc = in_play && ate_power_cookie_stb;
        expired = frame_stb && (m_timer == 1);
        start = any_btn && m_arm;
        m_pfs = frame_stb && in_play;
        m_respawn = '0; m_pos_reset = 0; m_map_reload = 0;
        if (frame_stb && m_timer > 0) m_timer--;
        nm = m_mode;
        nc = m_candies + int'(cd) + int'(pc);
        if (nc > CC) nc = CC;
        ns = m_score + int'(cd) + (pc ? PP : 0);
        case (m_mode)
            LOADING: if (expired) nm = READY;
            READY:   if (start) nm = PLAY;
            PLAY: begin
                if (h != 0) begin nm = DYING; m_timer = DF; end
                else if (nc == CC) begin nm = LEVEL_CLEAR; m_timer = CF; end
                else if (pc) begin nm = FRIGHT; m_timer = FF; end
            end
            FRIGHT: begin
                if (nc == CC) begin nm = LEVEL_CLEAR; m_timer = CF; m_eaten = '0; end
                else begin
                    fresh = h & ~m_eaten;
                    ns += GP * $countones(fresh);
                    m_respawn = fresh;
                    m_eaten = h;
                    if (pc) m_timer = FF;
                    else if (expired) begin nm = PLAY; m_eaten = '0; end
                end
            end
            DYING: if (expired) begin
                m_lives--;
                if (m_lives == 0) nm = GAME_OVER;
                else begin nm = READY; m_pos_reset = 1; end
            end
            LEVEL_CLEAR: if (expired) begin
                m_level = (m_level + 1) % (1 << LW);
                nc = 0; m_map_reload = 1; m_pos_reset = 1; nm = READY;
            end
            GAME_OVER: if (start) begin
                nm = LOADING; m_timer = LF; ns = 0; m_lives = LV; m_level = 0;
                nc = 0; m_map_reload = 1;
            end
            default: ;
        endcase
        if (ns > (1 << SW) - 1) ns = (1 << SW) - 1;
        m_candies = nc;
        m_score = ns;
        if (nm != m_mode) m_arm = 0;
        else if ((m_mode == READY || m_mode == GAME_OVER) && !any_btn) m_arm = 1;
        m_mode = nm;
    endtask

    // Every-cycle comparison of all outputs against the model
    always @(negedge vga_pix_clk) begin
        if (check_en) begin
            check("mode", int'(mode), int'(m_mode));
            check("play_frame_stb", int'(play_frame_stb), int'(m_pfs));
            check("frightened", int'(frightened), int'(m_mode == FRIGHT));
            check("enemy_respawn", int'(enemy_respawn), int'(m_respawn));
            check("positions_reset", int'(positions_reset), int'(m_pos_reset));
            check("map_reload", int'(map_reload), int'(m_map_reload));
            check("score", int'(score), m_score);
            check("lives", int'(lives), m_lives);
            check("level", int'(level), m_level);
        end
    end

    // One clock with the inputs as currently set; returns at negedge+1
    task automatic cyc();
        model_advance();
        @(negedge vga_pix_clk);
        #1;
    endtask

    task automatic frame_once();
        frame_stb = 1'b1; cyc(); frame_stb = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin
            frame_once(); cyc(); cyc(); cyc();
        end
    endtask

    task automatic press();
        any_btn = 1'b0; cyc(); any_btn = 1'b1; cyc();
    endtask

    task automatic pulse_candy(input int n);
        for (int k = 0; k < n; k++) begin
            ate_candy_stb = 1'b1; cyc(); ate_candy_stb = 1'b0; cyc();
        end
    endtask

    task automatic enemies_far();
        x_enemy = {NE{9'd300}}; y_enemy = {NE{9'd300}};
        x_pac = 9'd100; y_pac = 9'd100;
    endtask

    task automatic set_enemy(input int i, input int x, input int y);
        x_enemy[i*PW +: PW] = PW'(x);
        y_enemy[i*PW +: PW] = PW'(y);
    endtask

    task automatic do_reset();
        check_en = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge vga_pix_clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        check_en = 1'b1;
    endtask

    initial begin
        enemies_far();
        any_btn = 1'b1;
        do_reset();
        check("rst_mode", int'(mode), int'(LOADING));
        check("rst_score", int'(score), 0);
        check("rst_lives", int'(lives), LV);
        check("rst_level", int'(level), 0);

        // Loading, then a held button must not start play
        frames(LF);
        check("loaded_ready", int'(mode), int'(READY));
        repeat (20) cyc();
        check("held_btn_ready", int'(mode), int'(READY));
        press();
        check("armed_press_play", int'(mode), int'(PLAY));

        // Candies and a power cookie
        pulse_candy(10);
        ate_power_cookie_stb = 1'b1; cyc(); ate_power_cookie_stb = 1'b0;
        check("score_15", int'(score), 15);
        check("fright_on", int'(frightened), 1);

        // Two enemies eaten in the same cycle
        set_enemy(0, 103, 100);
        set_enemy(2, 98, 101);
        cyc();
        check("respawn_0101", int'(enemy_respawn), 5);
        check("score_55", int'(score), 55);
        repeat (3) cyc();
        check("respawn_held", int'(enemy_respawn), 0);
        check("score_held", int'(score), 55);
        enemies_far();
        frames(FF);
        check("fright_end_mode", int'(mode), int'(PLAY));
        check("fright_end_flag", int'(frightened), 0);

        // Collision boundary, then death on the candy that fills the level
        set_enemy(1, 104, 100);
        cyc();
        check("dist4_no_hit", int'(mode), int'(PLAY));
        set_enemy(1, 103, 100);
        ate_candy_stb = 1'b1; cyc(); ate_candy_stb = 1'b0;
        check("hit_beats_clear", int'(mode), int'(DYING));
        enemies_far();
        frames(DF - 1);
        frame_once();
        check("death_lives", int'(lives), 1);
        check("death_pos_reset", int'(positions_reset), 1);
        check("death_ready", int'(mode), int'(READY));

        // Full candy count carried over clears the level on return to play
        press();
        cyc();
        check("level_clear", int'(mode), int'(LEVEL_CLEAR));
        frames(CF - 1);
        frame_once();
        check("clear_level", int'(level), 1);
        check("clear_reload", int'(map_reload), 1);
        check("clear_score", int'(score), 56);

        // Last life lost, then restart from game over
        press();
        set_enemy(0, 100, 100);
        cyc();
        check("second_death", int'(mode), int'(DYING));
        enemies_far();
        frames(DF);
        check("game_over", int'(mode), int'(GAME_OVER));
        check("game_over_lives", int'(lives), 0);
        press();
        check("restart_loading", int'(mode), int'(LOADING));
        check("restart_score", int'(score), 0);
        check("restart_lives", int'(lives), LV);
        check("restart_level", int'(level), 0);

        // Randomised play against the model
        for (int c = 0; c < 8000; c++) begin
            frame_stb = ($urandom_range(2) == 0);
            if ($urandom_range(7) == 0) any_btn = ~any_btn;
            ate_candy_stb = ($urandom_range(5) == 0);
            ate_power_cookie_stb = ($urandom_range(59) == 0);
            if ((c % 16) == 0) begin
                case ($urandom_range(3))
                    0: x_pac = PW'($urandom_range(2));
                    1: x_pac = PW'(509 + $urandom_range(2));
                    default: x_pac = PW'($urandom_range(511));
                endcase
                y_pac = PW'($urandom_range(511));
                for (int i = 0; i < NE; i++) begin
                    if ($urandom_range(9) == 0)
                        set_enemy(i, (int'(x_pac) + $urandom_range(12) - 6 + 512) % 512,
                                     (int'(y_pac) + $urandom_range(12) - 6 + 512) % 512);
                    else
                        set_enemy(i, $urandom_range(511), $urandom_range(511));
                end
            end
            cyc();
        end
        frame_stb = 1'b0; ate_candy_stb = 1'b0; ate_power_cookie_stb = 1'b0;

        // Asynchronous reset in the middle of FRIGHT
        enemies_far();
        do_reset();
        frames(LF);
        press();
        ate_power_cookie_stb = 1'b1; cyc(); ate_power_cookie_stb = 1'b0;
        repeat (5) cyc();
        check("pre_reset_fright", int'(frightened), 1);
        check_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_fright_off", int'(frightened), 0);
        check("async_mode", int'(mode), int'(LOADING));
        check("async_score", int'(score), 0);
        @(negedge vga_pix_clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        check_en = 1'b1;
        frames(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
